sdp_ram_be_fill: RTL

- Parametrised simple dual-port block RAM with one clock, active-low write and active-low per-byte write enables, and a registered read port.
- Successor to the fixed 1K x 16 colour RAM. Generalises data width, byte-lane count, depth and read latency.
- Adds read-during-write forwarding and a hardware fill engine that sweeps the whole array with a constant value, e.g. palette clear or attribute wipe.
- Sits between the CPU/bus write side and the video fetch read side.

---
 rtl/sdp_ram_be_fill_if.sv | 28 ++
 rtl/sdp_ram_be_fill.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sdp_ram_be_fill_if.sv
// Bus bundle for sdp_ram_be_fill: write port, read port and fill-engine control.
// The master side is the CPU/bus plus video-fetch user; the slave side is the RAM.
interface sdp_ram_be_fill_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    localparam int BYTES = DATA_W / 8;

    logic              we;
    logic [BYTES-1:0]  be_n;
    logic [ADDR_W-1:0] addr_w;
    logic [DATA_W-1:0] data_w;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic              fill_req;
    logic [DATA_W-1:0] fill_val;
    logic              busy;

    modport master (
        output we, be_n, addr_w, data_w, addr_r, fill_req, fill_val,
        input  data_r, busy
    );

    modport slave (
        input  we, be_n, addr_w, data_w, addr_r, fill_req, fill_val,
        output data_r, busy
    );
endinterface

// File: rtl/sdp_ram_be_fill.sv
// Simple dual-port RAM with byte enables, 1- or 2-cycle registered read and a fill engine.
// Define SDP_RAM_BYPASS_EN for write-first read-during-write; undefined gives read-first.
module sdp_ram_be_fill #(
    parameter int    DATA_W    = 16,
    parameter int    BYTES     = DATA_W / 8,
    parameter int    DEPTH     = 1024,
    parameter int    ADDR_W    = 10,
    parameter int    READ_LAT  = 1,
    parameter string INIT_FILE = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    sdp_ram_be_fill_if.slave      bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DONE
    } state_t;

    localparam int unsigned       DEPTH_U = DEPTH;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_fill_val;
    logic              r_busy;
    logic [DATA_W-1:0] r_rd1;

    logic              w_wr_en;
    logic [BYTES-1:0]  w_wr_lanes;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic [DATA_W-1:0] w_rd_raw;
    logic [DATA_W-1:0] w_rd_next;

    // The fill engine owns the write port in FILL; external writes pass only while IDLE.
    always_comb begin
        // NOTE: every output gets a value on every path, otherwise a latch is inferred.
        w_wr_en    = 1'b0;
        w_wr_lanes = ~bus.be_n;
        w_wr_addr  = bus.addr_w;
        w_wr_data  = bus.data_w;
        if (r_state == ST_FILL) begin
            w_wr_en    = 1'b1;
            w_wr_lanes = '1;
            w_wr_addr  = r_cnt;
            w_wr_data  = r_fill_val;
        end else if (r_state == ST_IDLE) begin
            w_wr_en    = !bus.we;
        end
    end

    assign w_wr_in_range = (32'(w_wr_addr) < DEPTH_U);
    assign w_rd_in_range = (32'(bus.addr_r) < DEPTH_U);

    // NOTE: the array is deliberately not reset; contents survive rst and clearing is the fill engine's job.
    always @(posedge clk) begin
        if (w_wr_en && w_wr_in_range) begin
            for (int i = 0; i < BYTES; i++) begin
                if (w_wr_lanes[i]) begin
                    r_mem[w_wr_addr][8*i +: 8] <= w_wr_data[8*i +: 8];
                end
            end
        end
    end

    assign w_rd_raw = w_rd_in_range ? r_mem[bus.addr_r] : '0;

`ifdef SDP_RAM_BYPASS_EN
    logic w_rdw_hit;
    assign w_rdw_hit = w_wr_en && w_wr_in_range && (w_wr_addr == bus.addr_r);

    always_comb begin
        w_rd_next = w_rd_raw;
        for (int i = 0; i < BYTES; i++) begin
            if (w_rdw_hit && w_wr_lanes[i]) begin
                w_rd_next[8*i +: 8] = w_wr_data[8*i +: 8];
            end
        end
    end
`else
    assign w_rd_next = w_rd_raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd1 <= '0;
        end else begin
            r_rd1 <= w_rd_next;
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] r_rd2;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rd2 <= '0;
            end else begin
                r_rd2 <= r_rd1;
            end
        end
        assign bus.data_r = r_rd2;
    end else begin : g_lat1
        assign bus.data_r = r_rd1;
    end

    // Busy covers FILL plus the single DONE cycle: DEPTH+1 cycles in total.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_fill_val <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.fill_req) begin
                        r_fill_val <= bus.fill_val;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (r_cnt == LAST) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;

endmodule
